// File: rtl/cat_drop_ctl.sv
// Falling-cat position controller: per-frame gravity fall, landing pulse, and an
// LFSR-chosen drop column, gated by the game FSM's run enable.
module cat_drop_ctl #(
  parameter int unsigned FLOOR_Y     = 536,
  parameter int unsigned START_Y     = 0,
  parameter int unsigned X_MAX       = 736,
  parameter int unsigned X_INIT      = 368,
  parameter int unsigned ACCEL       = 16,
  parameter int unsigned V_MAX       = 256,
  parameter int unsigned HOLD_FRAMES = 30,
  parameter logic [9:0]  LFSR_SEED   = 10'h2A5
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic        on,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        finish,
  output logic [7:0]  drops,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FALL   = 2'b01,
    LANDED = 2'b10
  } state_t;

  localparam logic [11:0] FLOOR_ROW = 12'(FLOOR_Y);
  localparam logic [15:0] START_FP  = 16'(START_Y * 16);
  localparam logic [15:0] FLOOR_FP  = 16'(FLOOR_Y * 16);
  localparam logic [11:0] ACCEL_V   = 12'(ACCEL);
  localparam logic [11:0] VMAX_V    = 12'(V_MAX);
  localparam logic [11:0] X_INIT_V  = 12'(X_INIT);
  localparam logic [11:0] X_MAX_V   = 12'(X_MAX);
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_FRAMES - 1);

  state_t      state, state_n;
  logic [11:0] vel, vel_n;
  logic [15:0] y_fp, y_fp_n;
  logic [7:0]  hold_cnt, hold_n;
  logic [11:0] x_n;
  logic        fin_n;
  logic [7:0]  drops_n;
  logic [9:0]  lfsr;
  logic        vblnk_q;
  logic        tick;

  logic [11:0] vel_sum, vel_cap, lfsr_w, col;
  logic [15:0] y_try;

  assign tick      = vblnk_in & ~vblnk_q;
  assign ypos      = y_fp[15:4];
  assign state_dbg = state;

  assign lfsr_w  = {2'b00, lfsr};
  assign col     = (lfsr_w <= X_MAX_V) ? lfsr_w : lfsr_w - (X_MAX_V + 12'd1);
  // Cap is chosen from the uncapped sum, so vel never wraps past V_MAX.
  assign vel_sum = vel + ACCEL_V;
  assign vel_cap = (vel_sum >= VMAX_V) ? VMAX_V : vel_sum;
  assign y_try   = y_fp + {4'b0000, vel_cap};

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      vel      <= '0;
      y_fp     <= START_FP;
      hold_cnt <= '0;
      xpos     <= X_INIT_V;
      finish   <= 1'b0;
      drops    <= '0;
      lfsr     <= LFSR_SEED;
      vblnk_q  <= 1'b0;
    end else begin
      state    <= state_n;
      vel      <= vel_n;
      y_fp     <= y_fp_n;
      hold_cnt <= hold_n;
      xpos     <= x_n;
      finish   <= fin_n;
      drops    <= drops_n;
      lfsr     <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      vblnk_q  <= vblnk_in;
    end
  end

  always_comb begin
    state_n = state;
    vel_n   = vel;
    y_fp_n  = y_fp;
    hold_n  = hold_cnt;
    x_n     = xpos;
    fin_n   = 1'b0;
    drops_n = drops;

    // Losing the run enable overrides everything, including a landing tick.
    if (!on) begin
      state_n = IDLE;
      y_fp_n  = START_FP;
      vel_n   = '0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          state_n = FALL;
        end
        FALL: begin
          if (y_try[15:4] >= FLOOR_ROW) begin
            y_fp_n  = FLOOR_FP;
            vel_n   = '0;
            hold_n  = '0;
            state_n = LANDED;
            fin_n   = 1'b1;
            drops_n = (drops == 8'hFF) ? drops : drops + 8'd1;
          end else begin
            vel_n  = vel_cap;
            y_fp_n = y_try;
          end
        end
        LANDED: begin
          hold_n = hold_cnt + 8'd1;
          if (hold_cnt == HOLD_LAST) begin
            x_n     = col;
            y_fp_n  = START_FP;
            vel_n   = '0;
            state_n = FALL;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cat_drop_ctl.sv
// Scoreboard bench for cat_drop_ctl: per-tick expectations queued by stimulus,
// popped by a monitor on the frame after each vblank rising edge.
module tb_cat_drop_ctl;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  logic vblnk = 1'b0, on = 1'b0;
  logic vblnk2 = 1'b0, on2 = 1'b0;

  logic [11:0] xpos, ypos, xpos2, ypos2;
  logic        finish, finish2;
  logic [7:0]  drops, drops2;
  logic [1:0]  state_dbg, state_dbg2;

  cat_drop_ctl dut (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk), .on(on),
    .xpos(xpos), .ypos(ypos), .finish(finish), .drops(drops), .state_dbg(state_dbg)
  );

  cat_drop_ctl #(.HOLD_FRAMES(1)) dut2 (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk2), .on(on2),
    .xpos(xpos2), .ypos(ypos2), .finish(finish2), .drops(drops2), .state_dbg(state_dbg2)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    string name;
    int    x;
    int    y;
    int    st;
    int    dr;
    int    fin;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   fin_cnt = 0;
  int   exp_x = 368;
  logic fin_prev = 1'b0, fin2_prev = 1'b0;
  logic [9:0] m_lfsr;
  logic vq, strobe;

  // Reference LFSR (x^10+x^7+1) and bench-side frame-tick detector.
  always @(posedge pclk or posedge rst) begin
    if (rst) begin
      m_lfsr <= 10'h2A5;
      vq     <= 1'b0;
      strobe <= 1'b0;
    end else begin
      m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
      vq     <= vblnk;
      strobe <= vblnk & ~vq;
    end
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp_v);
    end
  endtask

  function automatic int col(input logic [9:0] l);
    int v;
    v = int'(l);
    return (v <= 736) ? v : v - 737;
  endfunction

  function automatic int fall_y(input int n);
    return (n <= 16) ? (n * (n + 1)) / 2 : 136 + 16 * (n - 16);
  endfunction

  always @(negedge pclk) begin : monitor
    exp_t e;
    if (strobe) begin
      chk("lfsr", int'(dut.lfsr), int'(m_lfsr));
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow actual=empty expected=entry");
      end else begin
        e = q.pop_front();
        chk({e.name, "/x"},      int'(xpos),      e.x);
        chk({e.name, "/y"},      int'(ypos),      e.y);
        chk({e.name, "/state"},  int'(state_dbg), e.st);
        chk({e.name, "/drops"},  int'(drops),     e.dr);
        chk({e.name, "/finish"}, int'(finish),    e.fin);
      end
    end
    if (finish) begin
      chk("finish_single", int'(fin_prev), 0);
      fin_cnt++;
    end
    if (finish2) chk("finish2_single", int'(fin2_prev), 0);
    fin_prev  = finish;
    fin2_prev = finish2;
  end

  task automatic tick(input string nm, input int ey, input int est, input int edr,
                      input int efin, input bit relaunch, input logic new_on,
                      input int hi, input int lo);
    exp_t e;
    @(negedge pclk);
    if (relaunch) exp_x = col(m_lfsr);
    e = '{nm, exp_x, ey, est, edr, efin};
    q.push_back(e);
    on    = new_on;
    vblnk = 1'b1;
    repeat (hi) @(negedge pclk);
    vblnk = 1'b0;
    repeat (lo) @(negedge pclk);
  endtask

  task automatic tick2(output logic [9:0] cap);
    @(negedge pclk);
    cap    = m_lfsr;
    vblnk2 = 1'b1;
    @(negedge pclk);
    vblnk2 = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [9:0] cap;
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    @(negedge pclk);
    chk("reset/x", int'(xpos), 368);
    chk("reset/y", int'(ypos), 0);
    chk("reset/state", int'(state_dbg), 0);
    chk("reset/drops", int'(drops), 0);

    tick("enter_fall", 0, 1, 0, 0, 0, 1'b1, 3, 4);
    for (int n = 1; n <= 40; n++)
      tick($sformatf("fall%0d", n), fall_y(n), 1, 0, 0, 0, 1'b1, 3, 4);
    tick("land", 536, 2, 1, 1, 0, 1'b1, 3, 4);
    for (int k = 1; k <= 29; k++)
      tick($sformatf("hold%0d", k), 536, 2, 1, 0, 0, 1'b1, 3, 4);
    tick("relaunch", 0, 1, 1, 0, 1, 1'b1, 3, 4);
    chk("relaunch_x_range", int'(xpos <= 12'd736), 1);

    for (int n = 1; n <= 40; n++)
      tick($sformatf("fall2_%0d", n), fall_y(n), 1, 1, 0, 0, 1'b1, 3, 4);
    tick("land_with_off", 0, 0, 1, 0, 0, 1'b0, 3, 4);
    tick("restart", 0, 1, 1, 0, 0, 1'b1, 3, 4);
    tick("long_vblnk", 1, 1, 1, 0, 0, 1'b1, 1000, 4);
    chk("long_vblnk_hold", int'(ypos), 1);
    for (int n = 2; n <= 26; n++)
      tick($sformatf("fast%0d", n), fall_y(n), 1, 1, 0, 0, 1'b1, 1, 0);

    #2 rst = 1'b1;
    #1;
    chk("async_rst/x", int'(xpos), 368);
    chk("async_rst/y", int'(ypos), 0);
    chk("async_rst/finish", int'(finish), 0);
    chk("async_rst/drops", int'(drops), 0);
    chk("async_rst/state", int'(state_dbg), 0);
    exp_x = 368;
    @(negedge pclk);
    rst = 1'b0;
    on  = 1'b0;

    on2 = 1'b1;
    tick2(cap);
    chk("sat_enter/state", int'(state_dbg2), 1);
    for (int d = 1; d <= 256; d++) begin
      if (d > 1) begin
        tick2(cap);
        chk("sat_relaunch_x", int'(xpos2), col(cap));
        chk("sat_x_range", int'(xpos2 <= 12'd736), 1);
        chk("sat_lfsr_nonzero", int'(dut2.lfsr != 10'd0), 1);
      end
      for (int n = 1; n <= 41; n++) tick2(cap);
      chk("sat_finish", int'(finish2), 1);
      chk("sat_y", int'(ypos2), 536);
      chk("sat_drops", int'(drops2), (d > 255) ? 255 : d);
    end

    repeat (2) @(negedge pclk);
    chk("scoreboard_left", q.size(), 0);
    chk("finish_pulses", fin_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cat_drop_ctl.md
Name: cat_drop_ctl

Overview:
- Position controller for the falling cat sprite.
- Sits directly upstream of draw_cat and supplies its xpos/ypos.
- Advances once per video frame with gravity-style acceleration, and pulses `finish` on landing.
- Picks each new drop column from an internal LFSR; the game FSM gates it with `on` and counts drops via `finish`.

Parameters:
- FLOOR_Y, 536, landing row for the sprite top (600 - 64 sprite height)
- START_Y, 0, ypos at the start of each drop
- X_MAX, 736, largest legal xpos (800 - 64); must be >= 511
- X_INIT, 368, xpos after reset
- ACCEL, 16, velocity increment per frame, in 1/16 px/frame units
- V_MAX, 256, velocity cap, in 1/16 px/frame units (16 px/frame)
- HOLD_FRAMES, 30, frames spent in LANDED before the next drop
- LFSR_SEED, 10'h2A5, LFSR reset value; must be non-zero

Ports:
- pclk  input  1  pixel clock (40 MHz); all state on its rising edge
- rst  input  1  asynchronous reset, active-high
- vblnk_in  input  1  vertical blank from vga_timing; its rising edge is the frame tick
- on  input  1  run enable from the game FSM (high in PLAY)
- xpos  output  12  sprite left column
- ypos  output  12  sprite top row
- finish  output  1  one-cycle pulse on landing
- drops  output  8  landings since reset; saturates at 255
- state_dbg  output  2  current state (IDLE=00, FALL=01, LANDED=10), for LEDs

Behaviour:
- Reset values (async, immediate, valid mid-operation):
  - state=IDLE, xpos=X_INIT, ypos=START_Y, finish=0, drops=0
  - vel=0, y_fp=START_Y<<4, hold_cnt=0, lfsr=LFSR_SEED, vblnk_q=0
- Frame tick: tick = vblnk_in & ~vblnk_q, with vblnk_q registered every cycle. Exactly one cycle per frame.
- Position and velocity change only on tick cycles. xpos and ypos are registered and stable for the entire active frame.
- y_fp is 16-bit fixed point with 4 fractional bits; ypos = y_fp[15:4].
- LFSR:
  - 10-bit Fibonacci, taps x^10+x^7+1, steps every pclk cycle.
  - Can never reach zero.
  - Column candidate: c = lfsr if lfsr <= X_MAX, else lfsr - (X_MAX+1).
- IDLE:
  - ypos held at START_Y, vel=0, xpos held.
  - On tick with on=1: go to FALL; position does not move on that tick.
- FALL, on each tick:
  - vel_n = min(vel+ACCEL, V_MAX); y_n = y_fp + vel_n.
  - If y_n[15:4] >= FLOOR_Y: y_fp=FLOOR_Y<<4 (clamped, never overshoots), vel=0, hold_cnt=0, state=LANDED, finish=1 for that single cycle, drops += 1 (saturating).
  - Otherwise: vel=vel_n, y_fp=y_n.
- LANDED, on each tick:
  - hold_cnt += 1.
  - When hold_cnt reaches HOLD_FRAMES-1: xpos=c, y_fp=START_Y<<4, vel=0, state=FALL.
- on=0 in any state:
  - Next cycle state=IDLE, y_fp=START_Y<<4, vel=0; xpos and drops held.
  - If on=0 coincides with a landing tick, on=0 wins: no finish, no drops increment.
- finish is never high for two consecutive cycles, and is never asserted outside FALL->LANDED.
- Arithmetic: 12-bit vel; the compare against V_MAX happens before the cap, so no wrap.

Test Plan:
- Reset with rst=1 mid-fall (ypos~300) -> xpos=368, ypos=0, finish=0, drops=0 and state_dbg=00, all within the same cycle (asynchronous).
- on=1, 60 Hz vblnk ticks from IDLE:
  - first tick enters FALL with ypos=0
  - ypos after fall ticks 1..16 = n(n+1)/2, so 1,3,6,...,136
  - then +16 per tick
  - tick 41 gives ypos=536 with finish high exactly 1 cycle; drops=1
- After landing, 30 more ticks -> ypos=0, xpos in [0,736] and equal to the LFSR-derived c sampled at that cycle; state FALL.
- on deasserted on the same cycle as the landing tick -> state IDLE, ypos=0, finish stays 0, drops unchanged.
- Force 256 landings (run with HOLD_FRAMES=1) -> drops saturates at 255; xpos never exceeds 736 over all drops; LFSR never reads 0.
- vblnk_in held high for 1000 cycles -> only one tick, ypos advances once; vblnk glitch-free toggling at 2-cycle period -> one update per rising edge.
